// File: rtl/rx_framer_pkg.sv
// Shared types and constants for the receiver I/Q byte framer.
package rx_framer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam int unsigned BYTES_PER_SAMPLE = 6;
  localparam int unsigned SYNC_LEN         = 3;
  localparam int unsigned IDX_W            = 3;

  // One buffered I/Q pair; I occupies the upper half so bytes go out MSB first.
  typedef struct packed {
    logic [23:0] i;
    logic [23:0] q;
  } iq_t;

  // Select stream byte idx (0..5) of a sample: I[23:16] first, Q[7:0] last.
  function automatic logic [7:0] iq_byte(input iq_t s, input logic [IDX_W-1:0] idx);
    logic [7:0] b;
    b = 8'h00;
    case (idx)
      3'd0:    b = s.i[23:16];
      3'd1:    b = s.i[15:8];
      3'd2:    b = s.i[7:0];
      3'd3:    b = s.q[23:16];
      3'd4:    b = s.q[15:8];
      3'd5:    b = s.q[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/iq_sample_fifo.sv
// Synchronous I/Q sample FIFO; a push into a full FIFO is taken when a pop
// happens in the same cycle.
module iq_sample_fifo
  import rx_framer_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  iq_t                      i_wr_data,
  output iq_t                      o_rd_data,
  output iq_t                      o_rd_data_next,
  output logic                     o_full_c,
  output logic                     o_empty_c,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  iq_t           r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full_c       = (r_count == CW'(DEPTH));
  assign o_empty_c      = (r_count == '0);
  assign w_do_pop       = i_pop && !o_empty_c;
  assign w_do_push      = i_push && (!o_full_c || w_do_pop);
  assign o_rd_data      = r_mem[r_rd_ptr];
  assign o_rd_data_next = r_mem[AW'(r_rd_ptr + AW'(1))];
  assign o_count        = r_count;

  // Sample storage, written on every accepted push.
  always_ff @(posedge clock) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

  // Pointers and occupancy; simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= AW'(r_wr_ptr + AW'(1));
      if (w_do_pop)  r_rd_ptr <= AW'(r_rd_ptr + AW'(1));
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= CW'(r_count + CW'(1));
        2'b01:   r_count <= CW'(r_count - CW'(1));
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/rx_iq_framer.sv
// Buffers strobed I/Q pairs and emits sync-headed byte frames on a
// valid/ready stream; flags samples dropped while the buffer is full.
module rx_iq_framer
  import rx_framer_pkg::*;
#(
  parameter int unsigned SAMPLES_PER_FRAME = 8,
  parameter int unsigned DEPTH             = 16,
  parameter logic [7:0]  SYNC_BYTE         = 8'h7F
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_strobe,
  input  logic [23:0]            in_data_I,
  input  logic [23:0]            in_data_Q,
  output logic [7:0]             out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_sof,
  output logic                   out_eof,
  output logic [$clog2(DEPTH):0] fill,
  output logic                   overflow,
  input  logic                   overflow_clear
);

  localparam int unsigned      CW          = $clog2(DEPTH) + 1;
  localparam logic [IDX_W-1:0] LAST_SYNC   = IDX_W'(SYNC_LEN - 1);
  localparam logic [IDX_W-1:0] LAST_BYTE   = IDX_W'(BYTES_PER_SAMPLE - 1);
  localparam logic [CW-1:0]    FRAME_LEN   = CW'(SAMPLES_PER_FRAME);
  localparam logic [CW-1:0]    LAST_SAMPLE = CW'(SAMPLES_PER_FRAME - 1);

  state_t           r_state, w_state_nxt;
  logic [IDX_W-1:0] r_idx, w_idx_nxt;
  logic [CW-1:0]    r_scnt, w_scnt_nxt;
  logic [7:0]       r_out_data, w_data_nxt;
  logic             r_out_valid, w_valid_nxt;
  logic             r_out_sof, w_sof_nxt;
  logic             r_out_eof, w_eof_nxt;
  logic             r_overflow;
  logic             w_accept;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic             w_drop;
  iq_t              w_wr_sample;
  iq_t              w_head;
  iq_t              w_head_next;
  iq_t              w_head_sel;

  assign w_wr_sample = {in_data_I, in_data_Q};
  assign w_accept    = r_out_valid && out_ready;
  assign w_drop      = in_strobe && w_full && !w_pop;
  assign out_data    = r_out_data;
  assign out_valid   = r_out_valid;
  assign out_sof     = r_out_sof;
  assign out_eof     = r_out_eof;
  assign overflow    = r_overflow;

  iq_sample_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock          (clock),
    .reset          (reset),
    .i_push         (in_strobe),
    .i_pop          (w_pop),
    .i_wr_data      (w_wr_sample),
    .o_rd_data      (w_head),
    .o_rd_data_next (w_head_next),
    .o_full_c       (w_full),
    .o_empty_c      (w_empty),
    .o_count        (fill)
  );

  // Frame sequencer and output byte registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_scnt      <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_sof   <= 1'b0;
      r_out_eof   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_scnt      <= w_scnt_nxt;
      r_out_data  <= w_data_nxt;
      r_out_valid <= w_valid_nxt;
      r_out_sof   <= w_sof_nxt;
      r_out_eof   <= w_eof_nxt;
    end
  end

  // Next byte position, FIFO pop, and the byte to present for that position.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_scnt_nxt  = r_scnt;
    w_pop       = 1'b0;
    w_valid_nxt = 1'b0;
    w_data_nxt  = 8'h00;
    w_sof_nxt   = 1'b0;
    w_eof_nxt   = 1'b0;

    case (r_state)
      IDLE: begin
        if (fill >= FRAME_LEN) begin
          w_state_nxt = SYNC;
          w_idx_nxt   = '0;
        end
      end
      SYNC: begin
        if (w_accept) begin
          if (r_idx == LAST_SYNC) begin
            w_state_nxt = DATA;
            w_idx_nxt   = '0;
            w_scnt_nxt  = '0;
          end else begin
            w_idx_nxt = IDX_W'(r_idx + IDX_W'(1));
          end
        end
      end
      DATA: begin
        if (w_accept) begin
          if (r_idx == LAST_BYTE) begin
            w_pop      = !w_empty;
            w_idx_nxt  = '0;
            w_scnt_nxt = CW'(r_scnt + CW'(1));
            if (r_scnt == LAST_SAMPLE) w_state_nxt = IDLE;
          end else begin
            w_idx_nxt = IDX_W'(r_idx + IDX_W'(1));
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // After a pop the next sample is already at the FIFO's second slot.
    w_head_sel  = w_pop ? w_head_next : w_head;
    // The cycle that enters SYNC from IDLE still presents nothing.
    w_valid_nxt = (r_state != IDLE) && (w_state_nxt != IDLE);
    if (w_valid_nxt) begin
      if (w_state_nxt == SYNC) begin
        w_data_nxt = SYNC_BYTE;
        w_sof_nxt  = (w_idx_nxt == '0);
      end else begin
        w_data_nxt = iq_byte(w_head_sel, w_idx_nxt);
        w_eof_nxt  = (w_idx_nxt == LAST_BYTE) && (w_scnt_nxt == LAST_SAMPLE);
      end
    end
  end

  // Sticky drop flag; a new drop wins over a same-cycle clear.
  always_ff @(posedge clock) begin
    if (reset)               r_overflow <= 1'b0;
    else if (w_drop)         r_overflow <= 1'b1;
    else if (overflow_clear) r_overflow <= 1'b0;
  end

endmodule

// File: tb/tb_rx_iq_framer.sv
// Directed bench for rx_iq_framer: framing, latency, stalls, overflow, reset.
module tb_rx_iq_framer;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_strobe;
  logic [23:0] in_data_I;
  logic [23:0] in_data_Q;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_sof;
  logic        out_eof;
  logic [4:0]  fill;
  logic        overflow;
  logic        overflow_clear;

  int n_checks = 0;
  int n_fail   = 0;

  rx_iq_framer #(
    .SAMPLES_PER_FRAME (8),
    .DEPTH             (16),
    .SYNC_BYTE         (8'h7F)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .in_strobe      (in_strobe),
    .in_data_I      (in_data_I),
    .in_data_Q      (in_data_Q),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_sof        (out_sof),
    .out_eof        (out_eof),
    .fill           (fill),
    .overflow       (overflow),
    .overflow_clear (overflow_clear)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] samp_i(input int k);
    return 24'(24'h123456 + 24'(k));
  endfunction

  function automatic logic [23:0] samp_q(input int k);
    return 24'(24'hABCDEF - 24'(k));
  endfunction

  // Expected byte at frame position pos for a frame whose first sample index is base.
  function automatic logic [7:0] exp_byte(input int base, input int pos);
    logic [47:0] w;
    int s;
    int b;
    if (pos < 3) return 8'h7F;
    s = (pos - 3) / 6;
    b = (pos - 3) % 6;
    w = {samp_i(base + s), samp_q(base + s)};
    return w[47 - 8*b -: 8];
  endfunction

  task automatic push(input int k);
    in_data_I = samp_i(k);
    in_data_Q = samp_q(k);
    in_strobe = 1'b1;
    step();
    in_strobe = 1'b0;
  endtask

  // Consume a frame from position start_pos, optionally with random back-pressure.
  task automatic drain(input int base, input int start_pos, input bit rnd);
    int  j;
    int  guard;
    logic rdy;
    j = start_pos;
    guard = 0;
    while (!out_valid && guard < 20) begin
      step();
      guard++;
    end
    guard = 0;
    while (j < 51 && guard < 1000) begin
      check($sformatf("valid_b%0d_p%0d", base, j), 32'(out_valid), 32'(1));
      check($sformatf("data_b%0d_p%0d", base, j), 32'(out_data), 32'(exp_byte(base, j)));
      check($sformatf("sof_b%0d_p%0d", base, j), 32'(out_sof), 32'(j == 0));
      check($sformatf("eof_b%0d_p%0d", base, j), 32'(out_eof), 32'(j == 50));
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready = rdy;
      step();
      if (rdy) j++;
      guard++;
    end
    check($sformatf("frame_done_b%0d", base), 32'(j), 32'(51));
    check($sformatf("idle_after_eof_b%0d", base), 32'(out_valid), 32'(0));
  endtask

  initial begin
    reset          = 1'b1;
    in_strobe      = 1'b0;
    in_data_I      = '0;
    in_data_Q      = '0;
    out_ready      = 1'b1;
    overflow_clear = 1'b0;
    step();
    step();
    check("rst_valid", 32'(out_valid), 32'(0));
    check("rst_data", 32'(out_data), 32'(0));
    check("rst_sof", 32'(out_sof), 32'(0));
    check("rst_eof", 32'(out_eof), 32'(0));
    check("rst_fill", 32'(fill), 32'(0));
    check("rst_overflow", 32'(overflow), 32'(0));
    reset = 1'b0;
    step();

    // Seven samples are not enough for a frame; the eighth starts one 2 cycles later.
    for (int k = 0; k < 7; k++) push(k);
    repeat (3) step();
    check("seven_valid", 32'(out_valid), 32'(0));
    check("seven_fill", 32'(fill), 32'(7));
    push(7);
    check("eighth_fill", 32'(fill), 32'(8));
    check("eighth_lat0", 32'(out_valid), 32'(0));
    step();
    check("eighth_lat1", 32'(out_valid), 32'(0));
    step();
    check("eighth_lat2", 32'(out_valid), 32'(1));
    drain(0, 0, 1'b0);
    check("frame0_fill", 32'(fill), 32'(0));

    // Random back-pressure must not change the byte sequence.
    out_ready = 1'b0;
    for (int k = 8; k < 16; k++) push(k);
    drain(8, 0, 1'b1);

    // Seventeen samples with the consumer stalled: last one dropped.
    out_ready = 1'b0;
    for (int k = 100; k < 116; k++) push(k);
    check("ovf_fill16", 32'(fill), 32'(16));
    check("ovf_before", 32'(overflow), 32'(0));
    push(116);
    check("ovf_fill_hold", 32'(fill), 32'(16));
    check("ovf_set", 32'(overflow), 32'(1));
    overflow_clear = 1'b1;
    step();
    overflow_clear = 1'b0;
    check("ovf_clear", 32'(overflow), 32'(0));
    drain(100, 0, 1'b0);
    drain(108, 0, 1'b0);
    check("ovf_17th_absent", 32'(fill), 32'(0));

    // Write while full coincident with acceptance of a sample's last byte.
    out_ready = 1'b0;
    for (int k = 200; k < 216; k++) push(k);
    check("coin_fill16", 32'(fill), 32'(16));
    out_ready = 1'b1;
    repeat (8) step();
    check("coin_byte5", 32'(out_data), 32'(exp_byte(200, 8)));
    in_data_I = samp_i(216);
    in_data_Q = samp_q(216);
    in_strobe = 1'b1;
    step();
    in_strobe = 1'b0;
    check("coin_fill_after", 32'(fill), 32'(16));
    check("coin_no_ovf", 32'(overflow), 32'(0));
    drain(200, 9, 1'b0);
    drain(208, 0, 1'b0);
    check("coin_stored", 32'(fill), 32'(1));
    for (int k = 217; k < 224; k++) push(k);
    drain(216, 0, 1'b0);

    // Reset in the middle of a frame abandons it.
    out_ready = 1'b1;
    for (int k = 300; k < 308; k++) push(k);
    for (int g = 0; g < 20 && !out_valid; g++) step();
    check("mid_start", 32'(out_sof), 32'(1));
    repeat (20) step();
    check("mid_byte20", 32'(out_data), 32'(exp_byte(300, 20)));
    reset = 1'b1;
    step();
    check("mid_rst_valid", 32'(out_valid), 32'(0));
    check("mid_rst_fill", 32'(fill), 32'(0));
    check("mid_rst_data", 32'(out_data), 32'(0));
    check("mid_rst_sof", 32'(out_sof), 32'(0));
    reset = 1'b0;
    step();
    for (int k = 400; k < 408; k++) push(k);
    drain(400, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
